uart_tx_fifo: RTL
=================

# uart_tx_fifo

- Buffered UART transmitter: accepts bytes over a strobe/ready handshake into an internal FIFO and serialises them 8N1 (8 data bits, LSB first), with optional parity and 1 or 2 stop bits.
- Transmit counterpart to the team's UART receiver; sits between on-chip byte producers and the FPGA `tx` pin.
- Replaces fixed-message transmit logic with a general byte stream.

## Interface
- `CLK_FREQ`, 50000000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bit/s.
- `BAUD_COUNT`, `CLK_FREQ/BAUD_RATE` (5208): clock cycles per bit; must be ≥ 2.
- `FIFO_DEPTH`, 16: entries; power of two, ≥ 2.
- `STOP_BITS`, 1: 1 or 2.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd; used only with parity compiled in.
- `clk` input 1: system clock; the only clock.
- `reset` input 1: reset, synchronous and active-high.
- `tx_data` input 8: byte to enqueue.
- `tx_start` input 1: write strobe; the byte is accepted in any cycle where `tx_start && tx_ready`.
- `tx_ready` output 1: FIFO not full; derived from the registered count.
- `tx` output 1: serial line, registered; idles high.
- `tx_busy` output 1: serialiser not in IDLE.
- `fifo_count` output `$clog2(FIFO_DEPTH)+1`: entries held, 0..`FIFO_DEPTH`.
- `tx_overflow` output 1: one-cycle pulse when `tx_start` arrives while full; that byte is dropped.

## Operation
- FIFO: circular buffer with wrapping read/write pointers and an explicit count.
- Full: `count == FIFO_DEPTH`. Empty: `count == 0`.
- Simultaneous push and pop leaves the count unchanged.
- A pop in a cycle does not free space for a push in the same cycle, because `tx_ready` uses the pre-edge count.
- Serialiser FSM states: IDLE, START, DATA, PARITY (parity builds only), STOP.
- IDLE, FIFO non-empty:
  - pop the head entry into the shift register;
  - drive `tx <= 0`;
  - clear the baud counter and bit counter;
  - go to START.
- Each bit is held for exactly `BAUD_COUNT` cycles. The baud counter runs 0..`BAUD_COUNT-1`, and the bit advances when it reaches `BAUD_COUNT-1`.
- START → DATA: drive bit 0.
- DATA: shift right and emit the next LSB. After bit 7 completes, go to PARITY, or to STOP when parity is not compiled in.
- STOP: `tx = 1` for `STOP_BITS × BAUD_COUNT` cycles.
- End of STOP:
  - FIFO non-empty: pop immediately and go to START, with no idle gap between frames;
  - otherwise go to IDLE.
- `tx_busy = (state != IDLE)`.
- Widths: the baud counter is sized to hold `BAUD_COUNT-1`. The bit counter is 4 bits.
- Reset values:
  - `tx` = 1, `tx_busy` = 0, `tx_ready` = 1, `fifo_count` = 0, `tx_overflow` = 0;
  - pointers = 0, FSM = IDLE.
- Reset mid-frame aborts the frame and flushes the FIFO. `tx` is high in the cycle after the reset edge.

## Timing
- Write latency: `tx_start` sampled at edge N gives `fifo_count` = 1 after edge N.
- Start of transmission: if the FSM is idle, it pops at edge N+1, so `tx` falls after edge N+1. First-byte latency is 2 cycles.
- Frame length: `(10 + P + STOP_BITS - 1) × BAUD_COUNT` cycles, where P = 1 when parity is compiled in.
- `tx_overflow` is asserted for the single cycle following the rejected strobe.
- `tx_data` must be valid only in the strobe cycle.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- Defined:
  - the PARITY state is inserted between DATA and STOP;
  - the parity bit is the XOR of the 8 data bits, inverted when `PARITY_ODD` = 1;
  - it is held for one bit time.
- Undefined:
  - no PARITY state and no parity logic;
  - the frame is pure 8N1 / 8N2;
  - `PARITY_ODD` is ignored.

## Test plan
Bench parameters: `CLK_FREQ=1000000`, `BAUD_RATE=100000` (`BAUD_COUNT=10`), parity undefined unless stated.
- Single byte: reset, then one `tx_start` with 0x48.
  - `tx` falls 2 cycles later.
  - Bit sequence, each bit 10 cycles: 0,0,0,0,1,0,0,1,0,1.
  - `tx_busy` is high for 100 cycles, then `tx` stays high.
- Burst: write "HelloWorld\n" (0x48 65 6C 6C 6F 57 6F 72 6C 64 0A) on 11 consecutive cycles.
  - 11 frames back-to-back, with no high gap beyond the stop bits.
  - Total 1100 cycles; bytes decode in order.
- Overflow: 18 writes on consecutive cycles from idle.
  - Writes 1–17 are accepted; `fifo_count` reaches 16.
  - Write 18 gives `tx_ready` = 0 and a 1-cycle `tx_overflow`.
  - Exactly 17 frames are sent.
- Reset mid-frame: assert `reset` during the DATA bit 3 of 0xA5, with 3 bytes queued.
  - `tx` = 1 and `fifo_count` = 0 next cycle.
  - No further frames are sent.
- Parity: `UART_TX_PARITY_EN` defined, `PARITY_ODD=0`, send 0x07.
  - Parity bit = 1; frame is 11 bit times (110 cycles).
  - With `PARITY_ODD=1`, parity bit = 0.
- Two stop bits: `STOP_BITS=2`, send 0x00 then 0xFF.
  - Stop-high interval is 20 cycles between frames.
  - Second start bit falls exactly 110 cycles after the first.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : uart_tx_fifo                                                   |
// | Brief   : FIFO-buffered 8-bit UART transmitter, LSB first, 1/2 stop bits.|
// |           Optional parity bit when UART_TX_PARITY_EN is defined.         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int BAUD_COUNT = CLK_FREQ / BAUD_RATE,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_start,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_overflow
);

  localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w  = c_ptr_w + 1;
  localparam int c_baud_w = $clog2(BAUD_COUNT);

  localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(BAUD_COUNT - 1);
  localparam logic [c_baud_w-1:0] c_baud_one  = c_baud_w'(1);
  localparam logic [3:0]          c_stop_last = 4'(STOP_BITS - 1);

  generate
    if (BAUD_COUNT < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_check
      $error("uart_tx_fifo: unsupported parameter set");
    end
  endgenerate

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
  } state_t;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;
  logic                r_overflow;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [7:0]          w_head;

  // Serialiser
  state_t              r_state, w_state_nxt;
  logic [c_baud_w-1:0] r_baud_cnt, w_baud_nxt;
  logic [3:0]          r_bit_cnt, w_bit_nxt;
  logic [7:0]          r_shift, w_shift_nxt;
  logic                r_tx, w_tx_nxt;
  logic                w_bit_done;
  logic                w_launch;
`ifdef UART_TX_PARITY_EN
  logic                r_parity;
`endif

  assign w_full   = (r_count == c_depth);
  assign w_empty  = (r_count == '0);
  assign w_push   = tx_start && !w_full;
  assign w_head   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
      r_overflow <= tx_start && w_full;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the byte as it leaves the FIFO, so the shifter is free to destroy it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_parity <= (^w_head) ^ (PARITY_ODD != 0);
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_bit_done  = (r_baud_cnt == c_baud_last);
    w_launch    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_launch = !w_empty;
      end
      S_START: begin
        if (w_bit_done) begin
          w_baud_nxt  = '0;
          w_tx_nxt    = r_shift[0];
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud_cnt + c_baud_one;
        end
      end
      S_DATA: begin
        if (w_bit_done) begin
          w_baud_nxt = '0;
          if (r_bit_cnt == 4'd7) begin
            w_bit_nxt   = '0;
`ifdef UART_TX_PARITY_EN
            w_tx_nxt    = r_parity;
            w_state_nxt = S_PARITY;
`else
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
            w_bit_nxt   = r_bit_cnt + 4'd1;
          end
        end else begin
          w_baud_nxt = r_baud_cnt + c_baud_one;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_done) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_tx_nxt    = 1'b1;
          w_state_nxt = S_STOP;
        end else begin
          w_baud_nxt = r_baud_cnt + c_baud_one;
        end
      end
`endif
      S_STOP: begin
        // The bit counter counts stop bits here, giving STOP_BITS whole bit times.
        if (w_bit_done) begin
          w_baud_nxt = '0;
          if (r_bit_cnt == c_stop_last) begin
            w_state_nxt = S_IDLE;
            w_launch    = !w_empty;
          end else begin
            w_bit_nxt = r_bit_cnt + 4'd1;
          end
        end else begin
          w_baud_nxt = r_baud_cnt + c_baud_one;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase

    // A launch from IDLE or from the tail of STOP starts the next frame with no gap.
    if (w_launch) begin
      w_shift_nxt = w_head;
      w_tx_nxt    = 1'b0;
      w_baud_nxt  = '0;
      w_bit_nxt   = '0;
      w_state_nxt = S_START;
    end
  end

  assign w_pop       = w_launch;
  assign tx_ready    = !w_full;
  assign tx          = r_tx;
  assign tx_busy     = (r_state != S_IDLE);
  assign fifo_count  = r_count;
  assign tx_overflow = r_overflow;

endmodule
`default_nettype wire
